// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32 pipeline, directly after execute.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_noop           executor slot is empty
//   in_opcode/funct3  instruction fields carried with the executor result
//   in_rd             destination register index
//   in_res            executor result (effective address for loads/stores)
//   in_rs2_data       store data
//   stall             upstream holds all in_* this cycle (combinational)
//   mem_req_*         data-memory request channel (registered outputs)
//   mem_resp_*        data-memory load response
//   out_*             writeback record, registered, one cycle after retirement
//   out_misaligned    one-cycle pulse when a misaligned access is dropped
//
// Handshake: a request transfers on a cycle where mem_req_valid and
// mem_req_ready are both high; while mem_req_valid is high the request payload
// is held stable. Load data is taken on any cycle mem_resp_valid is high while
// the stage waits for it. A response arriving in any other state is ignored.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_noop,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_res,
  input  logic [31:0] in_rs2_data,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_noop,
  output logic        out_rd_we,
  output logic [4:0]  out_rd,
  output logic [31:0] out_rd_data,
  output logic        out_misaligned
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Kept as a named signal so checkers can bind to the FSM state directly.
  state_t state;

  // Transaction context captured at accept time.
  logic [1:0] lane_q;
  logic [2:0] f3_q;
  logic [4:0] rd_q;

  // Decode of the presented instruction.
  logic is_load, is_store, is_alu, is_branch, f3_ok, is_mem, mis, mem_go;

  assign is_load   = (in_opcode == OP_LOAD);
  assign is_store  = (in_opcode == OP_STORE);
  assign is_branch = (in_opcode == OP_BRANCH);
  assign is_alu    = (in_opcode == OP_REG)  || (in_opcode == OP_IMM)  ||
                     (in_opcode == OP_JAL)  || (in_opcode == OP_JALR) ||
                     (in_opcode == OP_LUI)  || (in_opcode == OP_AUIPC);

  always_comb begin
    f3_ok = 1'b0;
    if (is_load) begin
      case (in_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_ok = 1'b1;
        default:                      f3_ok = 1'b0;
      endcase
    end else if (is_store) begin
      f3_ok = (in_funct3 <= 3'd2);
    end
  end

  assign is_mem = (is_load || is_store) && f3_ok;

  // funct3[1:0] encodes access size: 0 byte, 1 half, 2 word.
  assign mis = ((in_funct3[1:0] == 2'd1) && in_res[0]) ||
               ((in_funct3[1:0] == 2'd2) && (in_res[1:0] != 2'b00));

  assign mem_go = (state == S_IDLE) && !in_noop && is_mem && !mis;

  // Low on the cycle a transaction completes so upstream advances exactly
  // once; the held instruction is never re-decoded in REQ/RESP.
  assign stall = mem_go ||
                 ((state == S_REQ)  && !(mem_req_we && mem_req_ready)) ||
                 ((state == S_RESP) && !mem_resp_valid);

  // Store lane steering from the presented instruction.
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  always_comb begin
    st_wdata = in_rs2_data;
    st_wstrb = 4'b1111;
    case (in_funct3[1:0])
      2'd0: begin
        st_wdata = {4{in_rs2_data[7:0]}};
        st_wstrb = 4'b0001 << in_res[1:0];
      end
      2'd1: begin
        st_wdata = {2{in_rs2_data[15:0]}};
        st_wstrb = in_res[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = in_rs2_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load extraction and extension from the response word.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ld_byte = mem_resp_rdata[8*lane_q +: 8];
  assign ld_half = lane_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];

  always_comb begin
    ld_data = mem_resp_rdata;
    case (f3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = mem_resp_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= 32'd0;
      mem_req_wdata  <= 32'd0;
      mem_req_wstrb  <= 4'b0000;
      lane_q         <= 2'd0;
      f3_q           <= 3'd0;
      rd_q           <= 5'd0;
      out_noop       <= 1'b1;
      out_rd_we      <= 1'b0;
      out_rd         <= 5'd0;
      out_rd_data    <= 32'd0;
      out_misaligned <= 1'b0;
    end else begin
      // Default: nothing retires this cycle.
      out_noop       <= 1'b1;
      out_rd_we      <= 1'b0;
      out_misaligned <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!in_noop) begin
            if (is_alu) begin
              out_noop    <= 1'b0;
              out_rd_we   <= (in_rd != 5'd0);
              out_rd      <= in_rd;
              out_rd_data <= in_res;
            end else if (is_branch) begin
              out_noop    <= 1'b0;
            end else if (is_mem) begin
              if (mis) begin
                out_misaligned <= 1'b1;
              end else begin
                state         <= S_REQ;
                mem_req_valid <= 1'b1;
                mem_req_we    <= is_store;
                mem_req_addr  <= {in_res[31:2], 2'b00};
                mem_req_wdata <= st_wdata;
                mem_req_wstrb <= is_store ? st_wstrb : 4'b0000;
                lane_q        <= in_res[1:0];
                f3_q          <= in_funct3;
                rd_q          <= in_rd;
              end
            end
          end
        end

        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (mem_req_we) begin
              state    <= S_IDLE;
              out_noop <= 1'b0;
            end else begin
              state <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (mem_resp_valid) begin
            state       <= S_IDLE;
            out_noop    <= 1'b0;
            out_rd_we   <= (rd_q != 5'd0);
            out_rd      <= rd_q;
            out_rd_data <= ld_data;
          end
        end

        default: begin
          state         <= S_IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized bench for mem_stage. Inputs change on
// the falling edge; registered outputs are sampled on the falling edge and the
// combinational stall 1 ns after inputs change. Expected retirements come from
// an arithmetic model of the load/store rules and go through a queue.
module tb_mem_stage;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_MIS = 4, K_NOP = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_noop;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_res;
  logic [31:0] in_rs2_data;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_noop;
  logic        out_rd_we;
  logic [4:0]  out_rd;
  logic [31:0] out_rd_data;
  logic        out_misaligned;

  int n_checks = 0;
  int n_errors = 0;

  // Expected retirement record: {noop, misaligned, rd_we, rd[4:0], data[31:0]}
  logic [39:0] exp_q[$];

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_noop        (in_noop),
    .in_opcode      (in_opcode),
    .in_funct3      (in_funct3),
    .in_rd          (in_rd),
    .in_res         (in_res),
    .in_rs2_data    (in_rs2_data),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .out_noop       (out_noop),
    .out_rd_we      (out_rd_we),
    .out_rd         (out_rd),
    .out_rd_data    (out_rd_data),
    .out_misaligned (out_misaligned)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: classify the instruction and compute what it must produce.
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] rs2, input logic [31:0] rdata,
                       output int kind, output logic [31:0] data,
                       output logic [31:0] wdata, output logic [3:0] wstrb);
    int unsigned sz, lane, sh;
    logic [31:0] mask, v;
    logic valid_f3;
    kind = K_NOP; data = 32'd0; wdata = 32'd0; wstrb = 4'd0;
    lane = res % 4;
    sz = 1 << (f3 % 4);
    if (op == OP_LOAD)       valid_f3 = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else if (op == OP_STORE) valid_f3 = (f3 <= 2);
    else                     valid_f3 = 1'b0;
    if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b1101111 ||
        op == 7'b1100111 || op == 7'b0110111 || op == 7'b0010111) begin
      kind = K_ALU; data = res;
    end else if (op == OP_BRANCH) begin
      kind = K_BR;
    end else if (valid_f3) begin
      if (res % sz != 0) kind = K_MIS;
      else if (op == OP_LOAD) begin
        kind = K_LD;
        if (sz == 4) data = rdata;
        else begin
          sh   = (sz == 1) ? lane * 8 : (lane / 2) * 16;
          mask = (sz == 1) ? 32'hFF : 32'hFFFF;
          v    = (rdata >> sh) & mask;
          if (f3 < 4 && v > (mask >> 1)) v = v - (mask + 1);
          data = v;
        end
      end else begin
        kind = K_ST;
        if (sz == 1)      wdata = (rs2 & 32'hFF)   * 32'h0101_0101;
        else if (sz == 2) wdata = (rs2 & 32'hFFFF) * 32'h0001_0001;
        else              wdata = rs2;
        wstrb = 4'(((1 << sz) - 1) << lane);
      end
    end
    if (rd == 5'd0 && kind == K_ALU) data = res;
  endtask

  // Compare the registered writeback against the oldest expected record.
  task automatic check_retire(input string tag);
    logic [39:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_noop"}, 32'(out_noop), 32'(e[39]));
    chk({tag, "_mis"},  32'(out_misaligned), 32'(e[38]));
    chk({tag, "_we"},   32'(out_rd_we), 32'(e[37]));
    if (e[37]) begin
      chk({tag, "_rd"},   32'(out_rd), 32'(e[36:32]));
      chk({tag, "_data"}, out_rd_data, e[31:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left on a falling edge; on exit the instruction's retirement
  // (if any) is visible on out_*, and the next instruction may be driven.
  task automatic issue(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] res, input logic [31:0] rs2,
                       input int rdy_dly, input int resp_dly, input logic [31:0] rdata);
    int kind;
    logic [31:0] data, wdata;
    logic [3:0] wstrb;
    logic rd_we;
    model(op, f3, rd, res, rs2, rdata, kind, data, wdata, wstrb);
    rd_we = (kind == K_ALU || kind == K_LD) && (rd != 5'd0);
    exp_q.push_back({(kind == K_MIS || kind == K_NOP), (kind == K_MIS), rd_we, rd, data});

    in_noop = 1'b0; in_opcode = op; in_funct3 = f3; in_rd = rd;
    in_res = res; in_rs2_data = rs2;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    if (kind == K_LD || kind == K_ST) begin
      chk({tag, "_stall_accept"}, 32'(stall), 32'd1);
      @(posedge clk); @(negedge clk);
      for (int k = 0; k <= rdy_dly; k++) begin
        chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({tag, "_wait_noop"}, 32'(out_noop), 32'd1);
        if (k == 0) begin
          chk({tag, "_addr"},  mem_req_addr, res & 32'hFFFF_FFFC);
          chk({tag, "_we_req"}, 32'(mem_req_we), 32'(kind == K_ST));
          chk({tag, "_wstrb"}, 32'(mem_req_wstrb), 32'(wstrb));
          if (kind == K_ST) chk({tag, "_wdata"}, mem_req_wdata, wdata);
        end
        mem_req_ready = (k == rdy_dly);
        #1;
        chk({tag, "_stall_req"}, 32'(stall), 32'(!(kind == K_ST && mem_req_ready)));
        @(posedge clk); @(negedge clk);
      end
      mem_req_ready = 1'b0;
      if (kind == K_LD) begin
        for (int j = 0; j <= resp_dly; j++) begin
          chk({tag, "_resp_reqv"}, 32'(mem_req_valid), 32'd0);
          chk({tag, "_resp_noop"}, 32'(out_noop), 32'd1);
          mem_resp_valid = (j == resp_dly);
          mem_resp_rdata = (j == resp_dly) ? rdata : ~rdata;
          #1;
          chk({tag, "_stall_resp"}, 32'(stall), 32'(!mem_resp_valid));
          @(posedge clk); @(negedge clk);
        end
        mem_resp_valid = 1'b0;
      end
    end else begin
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      @(posedge clk); @(negedge clk);
      if (kind == K_MIS) chk({tag, "_no_req"}, 32'(mem_req_valid), 32'd0);
    end
    check_retire(tag);
    in_noop = 1'b1;
  endtask

  // One empty cycle: nothing may retire.
  task automatic idle_check(input string tag);
    in_noop = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({tag, "_idle_noop"}, 32'(out_noop), 32'd1);
    chk({tag, "_idle_we"},   32'(out_rd_we), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] op_tbl [13];

  initial begin
    op_tbl = '{7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111,
               7'b0010111, 7'b1100011, 7'b0000011, 7'b0000011, 7'b0100011,
               7'b0100011, 7'b0000000, 7'b1110011};
    rst = 1'b1; in_noop = 1'b1; in_opcode = 7'd0; in_funct3 = 3'd0; in_rd = 5'd0;
    in_res = 32'd0; in_rs2_data = 32'd0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_noop",  32'(out_noop), 32'd1);
    chk("rst_we",    32'(out_rd_we), 32'd0);
    chk("rst_rd",    32'(out_rd), 32'd0);
    chk("rst_data",  out_rd_data, 32'd0);
    chk("rst_mis",   32'(out_misaligned), 32'd0);
    chk("rst_reqv",  32'(mem_req_valid), 32'd0);
    rst = 1'b0;
    idle_check("post_rst");

    // Pass-through, with and without a real destination
    issue("add_rd5", OP_REG, 3'd0, 5'd5, 32'h1234, 32'd0, 0, 0, 32'd0);
    issue("add_rd0", OP_REG, 3'd0, 5'd0, 32'h1234, 32'd0, 0, 0, 32'd0);

    // Byte loads from lane 3, signed and unsigned
    issue("lb",  OP_LOAD, 3'd0, 5'd9, 32'h103, 32'd0, 2, 3, 32'h80FF_0000);
    issue("lbu", OP_LOAD, 3'd4, 5'd9, 32'h103, 32'd0, 2, 3, 32'h80FF_0000);

    // Half store to the upper lanes
    issue("sh", OP_STORE, 3'd1, 5'd3, 32'h202, 32'hAAAA_BEEF, 0, 0, 32'd0);

    // Misaligned word load is dropped
    issue("lw_mis", OP_LOAD, 3'd2, 5'd4, 32'h101, 32'd0, 0, 0, 32'd0);

    // Back-to-back: aligned LW then ADD accepted right after the response
    issue("lw_b2b",  OP_LOAD, 3'd2, 5'd6, 32'h104, 32'd0, 0, 0, 32'hCAFE_F00D);
    issue("add_b2b", OP_REG,  3'd0, 5'd7, 32'h5555, 32'd0, 0, 0, 32'd0);
    idle_check("b2b");

    // Undefined funct3 and branch
    issue("ld_f3_7", OP_LOAD, 3'd7, 5'd1, 32'h100, 32'd0, 0, 0, 32'd0);
    issue("br", OP_BRANCH, 3'd0, 5'd1, 32'h100, 32'd0, 0, 0, 32'd0);

    // Reset while a load waits for its response; a late response is ignored
    in_noop = 1'b0; in_opcode = OP_LOAD; in_funct3 = 3'd2; in_rd = 5'd8;
    in_res = 32'h300;
    @(posedge clk); @(negedge clk);
    mem_req_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_req_ready = 1'b0; in_noop = 1'b1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_2222;
    #1;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    @(posedge clk); @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("rst_mid_noop", 32'(out_noop), 32'd1);
    chk("rst_mid_we",   32'(out_rd_we), 32'd0);
    chk("rst_mid_reqv", 32'(mem_req_valid), 32'd0);
    idle_check("rst_mid");

    // Randomized mix checked against the model
    for (int i = 0; i < 60; i++) begin
      issue("rnd", op_tbl[$urandom_range(0, 12)], 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), $urandom & 32'h0000_0FFF, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) idle_check("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
